// File: rtl/risc_control_datapath.sv
// risc_control_datapath: ALU, branch comparator and six-state multi-cycle control sequencer.
// Ports: clk/rst (async active-high); opcode, imm_value, RSout, RTout, inst_addr in;
//        ALUout, BEQout, branch_addr, eight control strobes, one-hot S and T out.
module risc_control_datapath (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [15:0] imm_value,
    input  logic [31:0] RSout,
    input  logic [31:0] RTout,
    input  logic [31:0] inst_addr,
    output logic [31:0] ALUout,
    output logic        BEQout,
    output logic [31:0] branch_addr,
    output logic        InstRead,
    output logic        incPC,
    output logic        ldIR,
    output logic        ldPC,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegRead,
    output logic        RegWrite,
    output logic [0:7]  S,
    output logic [0:7]  T
);
    typedef enum logic [2:0] {S_FETCH, S_LOAD, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    state_t      r_state, w_next;
    logic [0:7]  r_t, w_t;
    logic [31:0] w_sext;
    logic [5:0]  w_funct;
    assign w_sext      = {{16{imm_value[15]}}, imm_value};
    assign w_funct     = imm_value[5:0];
    assign BEQout      = RSout == RTout;
    assign branch_addr = inst_addr + w_sext;
    assign S           = 8'h80 >> r_state;
    assign T           = r_t;
    always_comb begin
        w_t = 8'b0000_0100;
        case (opcode)
            6'd0:  w_t = 8'b1000_0000;
            6'd8:  w_t = 8'b0100_0000;
            6'd35: w_t = 8'b0010_0000;
            6'd43: w_t = 8'b0001_0000;
            6'd4:  w_t = 8'b0000_1000;
            default: ;
        endcase
    end
    always_comb begin
        ALUout = '0;
        case (opcode)
            6'd0: case (w_funct)
                6'h22:   ALUout = RSout - RTout;
                6'h24:   ALUout = RSout & RTout;
                6'h25:   ALUout = RSout | RTout;
                6'h2A:   ALUout = {31'b0, $signed(RSout) < $signed(RTout)};
                default: ALUout = RSout + RTout;
            endcase
            6'd8, 6'd35, 6'd43: ALUout = RSout + w_sext;
            6'd4:    ALUout = RSout - RTout;
            default: ;
        endcase
    end
    // T latches on the edge leaving LOAD, i.e. entering DECODE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_t     <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_LOAD) r_t <= w_t;
        end
    end
    // Async reset holds the state in FETCH, so only InstRead needs explicit rst gating
    always_comb begin
        w_next   = S_FETCH;
        InstRead = 1'b0;
        incPC    = 1'b0;
        ldIR     = 1'b0;
        ldPC     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegRead  = 1'b0;
        RegWrite = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_next   = S_LOAD;
                InstRead = ~rst;
            end
            S_LOAD: begin
                w_next = S_DECODE;
                ldIR   = 1'b1;
                incPC  = 1'b1;
            end
            S_DECODE: begin
                w_next  = S_EXEC;
                RegRead = 1'b1;
            end
            S_EXEC: begin
                w_next  = S_MEM;
                RegRead = 1'b1;
                ldPC    = r_t[4] & BEQout;
            end
            S_MEM: begin
                w_next   = S_WB;
                RegRead  = 1'b1;
                MemRead  = r_t[2];
                MemWrite = r_t[3];
            end
            S_WB: begin
                w_next   = S_FETCH;
                RegRead  = 1'b1;
                RegWrite = r_t[0] | r_t[1] | r_t[2];
            end
            default: w_next = S_FETCH;
        endcase
    end
endmodule

// File: tb/tb_risc_control_datapath.sv
// tb_risc_control_datapath: randomized bench with a behavioural cycle model and literal pins.
module tb_risc_control_datapath;
    logic        clk = 1'b0, rst = 1'b1;
    logic [5:0]  opcode = '0;
    logic [15:0] imm_value = '0;
    logic [31:0] RSout = '0, RTout = '0, inst_addr = '0;
    logic [31:0] ALUout, branch_addr;
    logic        BEQout, InstRead, incPC, ldIR, ldPC, MemRead, MemWrite, RegRead, RegWrite;
    logic [0:7]  S, T;
    logic [7:0]  strb;
    int          checks = 0, failures = 0;
    int          ph = 0, mt = -1;
    bit          go = 0;

    risc_control_datapath dut (
        .clk(clk), .rst(rst), .opcode(opcode), .imm_value(imm_value), .RSout(RSout),
        .RTout(RTout), .inst_addr(inst_addr), .ALUout(ALUout), .BEQout(BEQout),
        .branch_addr(branch_addr), .InstRead(InstRead), .incPC(incPC), .ldIR(ldIR),
        .ldPC(ldPC), .MemRead(MemRead), .MemWrite(MemWrite), .RegRead(RegRead),
        .RegWrite(RegWrite), .S(S), .T(T)
    );

    assign strb = {InstRead, incPC, ldIR, ldPC, MemRead, MemWrite, RegRead, RegWrite};

    always #5 clk = ~clk;

    task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
        end
    endtask

    function automatic int tp(input logic [5:0] op);
        case (op)
            6'd0:    return 0;
            6'd8:    return 1;
            6'd35:   return 2;
            6'd43:   return 3;
            6'd4:    return 4;
            default: return 5;
        endcase
    endfunction

    function automatic logic [31:0] m_alu(input logic [5:0] op, input logic [15:0] imm,
                                          input logic [31:0] rs, input logic [31:0] rt);
        int sx;
        sx = $signed(imm);
        case (tp(op))
            0: case (imm[5:0])
                6'h22:   return rs - rt;
                6'h24:   return rs & rt;
                6'h25:   return rs | rt;
                6'h2A:   return ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
                default: return rs + rt;
            endcase
            1, 2, 3: return rs + sx;
            4:       return rs - rt;
            default: return 32'd0;
        endcase
    endfunction

    // Model: phase counts cycles since reset modulo six; type is captured entering phase 2
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph = 0;
            mt = -1;
        end else begin
            ph = (ph + 1) % 6;
            if (ph == 2) mt = tp(opcode);
        end
    end

    always @(negedge clk) begin
        logic [0:7] es, et;
        logic [7:0] ex;
        int         sx;
        if (go) begin
            es = '0;
            es[ph] = 1'b1;
            et = '0;
            if (mt >= 0) et[mt] = 1'b1;
            ex = '0;
            if (!rst) begin
                ex[7] = ph == 0;
                ex[6] = ph == 1;
                ex[5] = ph == 1;
                ex[4] = ph == 3 && mt == 4 && RSout == RTout;
                ex[3] = ph == 4 && mt == 2;
                ex[2] = ph == 4 && mt == 3;
                ex[1] = ph >= 2;
                ex[0] = ph == 5 && (mt == 0 || mt == 1 || mt == 2);
            end
            sx = $signed(imm_value);
            check("S", {24'd0, S}, {24'd0, es});
            check("T", {24'd0, T}, {24'd0, et});
            check("strobes", {24'd0, strb}, {24'd0, ex});
            check("ALUout", ALUout, m_alu(opcode, imm_value, RSout, RTout));
            check("BEQout", {31'd0, BEQout}, {31'd0, RSout == RTout});
            check("branch_addr", branch_addr, inst_addr + sx);
        end
    end

    task automatic pin(input logic [5:0] op, input logic [15:0] imm, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] exp);
        opcode = op; imm_value = imm; RSout = rs; RTout = rt;
        #1;
        check("pin_dut_alu", ALUout, exp);
        check("pin_model_alu", m_alu(op, imm, rs, rt), exp);
    endtask

    initial begin
        logic [7:0] seq [6];
        int         r;
        seq = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04};
        #2 go = 1;
        pin(6'd0,  16'h0020, 32'd5,        32'd7,      32'd12);
        pin(6'd0,  16'h0022, 32'd3,        32'd5,      32'hFFFF_FFFE);
        pin(6'd0,  16'h002A, 32'hFFFF_FFFF, 32'd2,     32'd1);
        pin(6'd0,  16'h0024, 32'h0000_F0F0, 32'h0FF0,  32'h0000_00F0);
        pin(6'd0,  16'h0025, 32'h0000_F0F0, 32'h0FF0,  32'h0000_FFF0);
        pin(6'd8,  16'hFFFF, 32'd10,       32'd0,      32'd9);
        pin(6'd35, 16'h0004, 32'h100,      32'd0,      32'h104);
        pin(6'd43, 16'h0004, 32'h100,      32'd0,      32'h104);
        pin(6'd2,  16'h1234, 32'd77,       32'd9,      32'd0);
        inst_addr = 32'd6;
        pin(6'd4,  16'hFFFC, 32'd9,        32'd9,      32'd0);
        check("pin_branch", branch_addr, 32'd2);
        check("pin_beq", {31'd0, BEQout}, 32'd1);
        opcode = 6'd0; imm_value = 16'h0020;
        @(posedge clk); #1 rst = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("seq_S", {24'd0, S}, {24'd0, seq[i % 6]});
            if (i < 2) check("seq_T0", {24'd0, T}, 32'd0);
        end
        opcode = 6'd4; imm_value = 16'hFFFC; inst_addr = 32'd6; RSout = 32'd9; RTout = 32'd9;
        repeat (4) @(negedge clk);
        check("beq_ldPC", {31'd0, ldPC}, 32'd1);
        check("beq_incPC", {31'd0, incPC}, 32'd0);
        check("beq_target", branch_addr, 32'd2);
        #2 rst = 1;
        #1;
        check("arst_S", {24'd0, S}, 32'h80);
        check("arst_T", {24'd0, T}, 32'd0);
        check("arst_strb", {24'd0, strb}, 32'd0);
        @(posedge clk); #1 rst = 0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            r = $urandom_range(0, 5);
            opcode = r == 0 ? 6'd0 : r == 1 ? 6'd8 : r == 2 ? 6'd35 : r == 3 ? 6'd43 :
                     r == 4 ? 6'd4 : 6'($urandom);
            r = $urandom_range(0, 5);
            imm_value = {10'($urandom), r == 0 ? 6'h20 : r == 1 ? 6'h22 : r == 2 ? 6'h24 :
                         r == 3 ? 6'h25 : r == 4 ? 6'h2A : 6'($urandom)};
            RSout = $urandom;
            RTout = ($urandom_range(0, 3) == 0) ? RSout : $urandom;
            inst_addr = $urandom;
            if (c % 97 == 50) begin
                #2 rst = 1;
                #1;
                check("rnd_arst_S", {24'd0, S}, 32'h80);
                check("rnd_arst_strb", {24'd0, strb}, 32'd0);
                @(posedge clk); #1 rst = 0;
            end
        end
        @(negedge clk);
        go = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
